// File: rtl/ft_tx_sched.sv
// ft_tx_sched: packet scheduler for the FT600 write path.
//
// Shares one FT write stream between the AFE sample FIFO (IQ pairs) and the
// CPU command FIFO. It arbitrates per packet and emits one header word ahead
// of PKT_WORDS payload words. Both source FIFOs are non-show-ahead: Q is
// valid one clk after re.
//
// Ports:
//   clk, reset_n       clock (FT domain), async active-low reset
//   loopback           1 = sample source never granted
//   samp_*             sample FIFO read port (data, empty, enough, re)
//   cmd_*              cmd FIFO read port (data, empty, block count, re)
//   tx_data_o/valid_o  output word stream, accepted on valid & tx_ready_i
//   grant_o            00 none, 01 samples, 10 cmd
//   pkt_seq_o          packet sequence number, advances on header accept
//   underrun_o         sticky: granted source ran empty mid-packet
module ft_tx_sched #(
  parameter int unsigned FT_DATA_WIDTH = 32,
  parameter int unsigned IQ_PAIR_WIDTH = 24,
  parameter int unsigned PKT_WORDS     = 32,
  parameter int unsigned MAX_CMD_BURST = 2,
  parameter int unsigned BLKCNT_WIDTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     loopback,
  input  logic [IQ_PAIR_WIDTH-1:0] samp_data_i,
  input  logic                     samp_empty_i,
  input  logic                     samp_enough_i,
  output logic                     samp_re_o,
  input  logic [FT_DATA_WIDTH-1:0] cmd_data_i,
  input  logic                     cmd_empty_i,
  input  logic [BLKCNT_WIDTH-1:0]  cmd_blkcnt_i,
  output logic                     cmd_re_o,
  output logic [FT_DATA_WIDTH-1:0] tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  output logic [1:0]               grant_o,
  output logic [7:0]               pkt_seq_o,
  output logic                     underrun_o
);

  localparam int unsigned STREAK_W = (MAX_CMD_BURST < 1) ? 1 : $clog2(MAX_CMD_BURST + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CMD_BURST);
  localparam logic [7:0] PKT_W8 = 8'(PKT_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_BODY
  } state_t;

  state_t                   state;
  logic                     is_cmd;
  logic [STREAK_W-1:0]      streak;
  logic [7:0]               rd_left;   // payload reads still to issue
  logic [7:0]               tx_left;   // payload words still to hand off
  logic                     inflight;  // read issued last clk, Q valid now
  logic [FT_DATA_WIDTH-1:0] pbuf0;
  logic [FT_DATA_WIDTH-1:0] pbuf1;
  logic [1:0]               pcnt;

  logic                     src_empty;
  logic [1:0]               occ;
  logic                     rd_en;
  logic [FT_DATA_WIDTH-1:0] q_word;
  logic                     cmd_ok;
  logic                     samp_ok;
  logic                     grant_cmd;
  logic                     grant_samp;
  logic                     fire;
  logic                     last_fire;
  logic                     load_out;
  logic                     pop;
  logic                     take_q;
  logic                     push;
  logic [31:0]              hdr_word;
  logic [FT_DATA_WIDTH-1:0] nb0;
  logic [FT_DATA_WIDTH-1:0] nb1;
  logic [1:0]               ncnt;

  // Read enables are decoded from registered state plus the live empty flag
  // so a read can be issued in the same clk the FIFO becomes non-empty.
  always_comb begin
    src_empty  = is_cmd ? cmd_empty_i : samp_empty_i;
    occ        = pcnt + {1'b0, inflight};
    rd_en      = (state != ST_IDLE) && (rd_left != 8'd0) && (occ < 2'd2) && !src_empty;
    samp_re_o  = rd_en & ~is_cmd;
    cmd_re_o   = rd_en & is_cmd;
    q_word     = is_cmd ? cmd_data_i : FT_DATA_WIDTH'(samp_data_i);

    cmd_ok     = (cmd_blkcnt_i != '0);
    samp_ok    = samp_enough_i & ~loopback;
    grant_cmd  = cmd_ok & ~((streak == STREAK_MAX) & samp_ok);
    grant_samp = ~grant_cmd & samp_ok;
    hdr_word   = {8'hA5, grant_cmd, 7'b0, pkt_seq_o, PKT_W8};

    fire       = tx_valid_o & tx_ready_i;
    last_fire  = (state == ST_BODY) && fire && (tx_left == 8'd1);
    // The output register refills when the header leaves, or in BODY when
    // it is empty or being drained this clk.
    load_out   = ((state == ST_HDR) && fire) ||
                 ((state == ST_BODY) && (!tx_valid_o || tx_ready_i) && !last_fire);
    pop        = load_out && (pcnt != 2'd0);
    take_q     = load_out && (pcnt == 2'd0) && inflight;
    push       = inflight && !take_q;

    nb0  = pbuf0;
    nb1  = pbuf1;
    ncnt = pcnt;
    if (pop) begin
      nb0  = pbuf1;
      ncnt = ncnt - 2'd1;
    end
    if (push) begin
      if (ncnt == 2'd0) begin
        nb0 = q_word;
      end else begin
        nb1 = q_word;
      end
      ncnt = ncnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      is_cmd     <= 1'b0;
      streak     <= '0;
      rd_left    <= '0;
      tx_left    <= '0;
      inflight   <= 1'b0;
      pbuf0      <= '0;
      pbuf1      <= '0;
      pcnt       <= '0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      grant_o    <= '0;
      pkt_seq_o  <= '0;
      underrun_o <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        rd_left <= rd_left - 8'd1;
      end
      pbuf0 <= nb0;
      pbuf1 <= nb1;
      pcnt  <= ncnt;

      if (load_out) begin
        tx_valid_o <= pop | take_q;
        if (pop) begin
          tx_data_o <= pbuf0;
        end else if (take_q) begin
          tx_data_o <= q_word;
        end
      end

      case (state)
        ST_IDLE: begin
          if (grant_cmd || grant_samp) begin
            state      <= ST_HDR;
            is_cmd     <= grant_cmd;
            grant_o    <= grant_cmd ? 2'b10 : 2'b01;
            tx_data_o  <= FT_DATA_WIDTH'(hdr_word);
            tx_valid_o <= 1'b1;
            rd_left    <= PKT_W8;
            tx_left    <= PKT_W8;
            if (grant_cmd) begin
              if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
              end
            end else begin
              streak <= '0;
            end
          end
        end
        ST_HDR: begin
          if (fire) begin
            pkt_seq_o <= pkt_seq_o + 8'd1;
            state     <= ST_BODY;
          end
        end
        ST_BODY: begin
          if ((rd_left != 8'd0) && src_empty) begin
            underrun_o <= 1'b1;
          end
          if (fire) begin
            tx_left <= tx_left - 8'd1;
            if (tx_left == 8'd1) begin
              state      <= ST_IDLE;
              grant_o    <= '0;
              tx_valid_o <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft_tx_sched.sv
// tb_ft_tx_sched: directed self-checking bench for ft_tx_sched.
// Models both non-show-ahead source FIFOs, collects accepted output words and
// compares them against hand-computed headers and payload sequences.
module tb_ft_tx_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        loopback = 1'b0;
  logic [23:0] samp_data_i = '0;
  logic        samp_empty_i;
  logic        samp_enough_i;
  logic        samp_re_o;
  logic [31:0] cmd_data_i = '0;
  logic        cmd_empty_i;
  logic [3:0]  cmd_blkcnt_i;
  logic        cmd_re_o;
  logic [31:0] tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic [1:0]  grant_o;
  logic [7:0]  pkt_seq_o;
  logic        underrun_o;

  always #5 clk = ~clk;

  ft_tx_sched #(
    .FT_DATA_WIDTH(32),
    .IQ_PAIR_WIDTH(24),
    .PKT_WORDS(32),
    .MAX_CMD_BURST(2),
    .BLKCNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .loopback(loopback),
    .samp_data_i(samp_data_i),
    .samp_empty_i(samp_empty_i),
    .samp_enough_i(samp_enough_i),
    .samp_re_o(samp_re_o),
    .cmd_data_i(cmd_data_i),
    .cmd_empty_i(cmd_empty_i),
    .cmd_blkcnt_i(cmd_blkcnt_i),
    .cmd_re_o(cmd_re_o),
    .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .grant_o(grant_o),
    .pkt_seq_o(pkt_seq_o),
    .underrun_o(underrun_o)
  );

  // Source FIFO models: write pointers owned by the stimulus, read pointers
  // by the clocked read logic.
  logic [23:0] samp_mem [0:9215];
  logic [31:0] cmd_mem  [0:255];
  int          samp_wp = 0, samp_rp = 0, cmd_wp = 0, cmd_rp = 0;
  logic        samp_hold = 1'b0, samp_flush = 1'b0, cmd_flush = 1'b0;

  assign samp_empty_i  = samp_hold || (samp_wp == samp_rp);
  assign samp_enough_i = (samp_wp - samp_rp) >= 32;
  assign cmd_empty_i   = (cmd_wp == cmd_rp);
  assign cmd_blkcnt_i  = 4'((cmd_wp - cmd_rp) / 32);

  always @(posedge clk) begin
    if (samp_flush) samp_rp <= samp_wp;
    else if (samp_re_o) begin
      samp_data_i <= samp_mem[samp_rp];
      samp_rp     <= samp_rp + 1;
    end
    if (cmd_flush) cmd_rp <= cmd_wp;
    else if (cmd_re_o) begin
      cmd_data_i <= cmd_mem[cmd_rp];
      cmd_rp     <= cmd_rp + 1;
    end
  end

  logic rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    tx_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor, sampled on the falling edge.
  logic [31:0] out_mem [0:16383];
  int          out_wp = 0;
  int          samp_re_cnt = 0, cmd_re_cnt = 0, grant_seen = 0, hold_err = 0, re_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!tx_valid_o || tx_data_o != prev_data)) hold_err++;
      if (samp_re_o && cmd_re_o) re_err++;
      if ((samp_re_o || cmd_re_o) && grant_o == 2'b00) re_err++;
      if (samp_re_o) samp_re_cnt++;
      if (cmd_re_o) cmd_re_cnt++;
      if (grant_o != 2'b00) grant_seen++;
      if (tx_valid_o && tx_ready_i && out_wp < 16384) begin
        out_mem[out_wp] = tx_data_o;
        out_wp++;
      end
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_data  = tx_data_o;
    end
  end

  int n_cmp = 0, n_err = 0, out_rp = 0;
  bit abort = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic get_word(output logic [31:0] w);
    int t = 0;
    w = '0;
    while (!abort && out_rp == out_wp && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (out_rp != out_wp) begin
      w = out_mem[out_rp];
      out_rp++;
    end else if (!abort) begin
      abort = 1'b1;
      chk("word_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (!abort && (out_wp - out_rp) < n && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if ((out_wp - out_rp) < n && !abort) begin
      abort = 1'b1;
      chk("words_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic expect_pkt(input string tag, input logic src, input logic [7:0] seq,
                            input logic [31:0] first, input bit chk_pay);
    logic [31:0] w;
    get_word(w);
    chk({tag, "_hdr"}, w, {8'hA5, src, 7'b0, seq, 8'h20});
    chk({tag, "_grant"}, 32'(grant_o), src ? 32'd2 : 32'd1);
    for (int k = 0; k < 32; k++) begin
      get_word(w);
      if (chk_pay) chk({tag, "_pay"}, w, first + 32'(k));
    end
  endtask

  task automatic load_samp(input logic [23:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      samp_mem[samp_wp] = base + 24'(i);
      samp_wp++;
    end
  endtask

  task automatic load_cmd(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      cmd_mem[cmd_wp] = base + 32'(i);
      cmd_wp++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; samp_flush = 1'b1; cmd_flush = 1'b1;
    samp_hold = 1'b0; loopback = 1'b0; rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    samp_flush = 1'b0; cmd_flush = 1'b0;
    out_rp = out_wp;
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, g0, s0;
    logic [31:0] w;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(tx_valid_o), 0);
    chk("rst_data", tx_data_o, 0);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_seq", 32'(pkt_seq_o), 0);
    chk("rst_under", 32'(underrun_o), 0);
    chk("rst_re", 32'({samp_re_o, cmd_re_o}), 0);

    // Single sample packet
    load_samp(24'h000001, 40);
    expect_pkt("t1", 1'b0, 8'd0, 32'h1, 1'b1);
    cycles(3);
    chk("t1_seq", 32'(pkt_seq_o), 1);
    chk("t1_grant_clr", 32'(grant_o), 0);
    chk("t1_idle", 32'(tx_valid_o), 0);
    chk("t1_under", 32'(underrun_o), 0);

    // Cmd burst limit interleaving
    do_reset();
    load_samp(24'h000001, 64);
    load_cmd(32'hC0DE0000, 128);
    expect_pkt("t2p0", 1'b1, 8'd0, 32'hC0DE0000, 1'b1);
    expect_pkt("t2p1", 1'b1, 8'd1, 32'hC0DE0020, 1'b1);
    expect_pkt("t2p2", 1'b0, 8'd2, 32'h00000001, 1'b1);
    expect_pkt("t2p3", 1'b1, 8'd3, 32'hC0DE0040, 1'b1);
    expect_pkt("t2p4", 1'b1, 8'd4, 32'hC0DE0060, 1'b1);
    expect_pkt("t2p5", 1'b0, 8'd5, 32'h00000021, 1'b1);
    cycles(3);
    chk("t2_seq", 32'(pkt_seq_o), 6);
    chk("t2_under", 32'(underrun_o), 0);

    // Random back-pressure on a cmd packet
    do_reset();
    c0 = cmd_re_cnt;
    rand_ready = 1'b1;
    load_cmd(32'hC0DE0000, 32);
    expect_pkt("t3", 1'b1, 8'd0, 32'hC0DE0000, 1'b1);
    cycles(10);
    rand_ready = 1'b0;
    chk("t3_cmd_re", 32'(cmd_re_cnt - c0), 32);
    chk("t3_extra", 32'(out_wp - out_rp), 0);

    // Underrun mid-packet
    do_reset();
    load_samp(24'h000001, 40);
    wait_words(11);
    chk("t4_pre", 32'(underrun_o), 0);
    samp_hold = 1'b1;
    cycles(20);
    chk("t4_under", 32'(underrun_o), 1);
    chk("t4_stalled", 32'(tx_valid_o), 0);
    chk("t4_short", 32'((out_wp - out_rp) < 33), 1);
    samp_hold = 1'b0;
    expect_pkt("t4", 1'b0, 8'd0, 32'h1, 1'b1);
    cycles(3);
    chk("t4_sticky", 32'(underrun_o), 1);
    chk("t4_extra", 32'(out_wp - out_rp), 0);

    // Loopback blocks samples only
    do_reset();
    loopback = 1'b1;
    g0 = grant_seen;
    s0 = samp_re_cnt;
    load_samp(24'h000001, 32);
    cycles(40);
    chk("t5_no_grant", 32'(grant_seen - g0), 0);
    chk("t5_no_samp_re", 32'(samp_re_cnt - s0), 0);
    load_cmd(32'hC0DE0000, 32);
    expect_pkt("t5", 1'b1, 8'd0, 32'hC0DE0000, 1'b1);
    cycles(3);
    chk("t5_samp_re", 32'(samp_re_cnt - s0), 0);

    // Sequence wrap, then reset mid-body
    do_reset();
    load_samp(24'h000001, 257 * 32);
    for (int p = 0; p < 256; p++) begin
      expect_pkt("t6", 1'b0, 8'(p), 32'(1 + 32 * p), p == 255);
    end
    chk("t6_wrap", 32'(pkt_seq_o), 0);
    get_word(w);
    chk("t6_hdr257", w, 32'hA5000020);
    wait_words(5);
    chk("t6_seq_mid", 32'(pkt_seq_o), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(tx_valid_o), 0);
    chk("t6_rst_data", tx_data_o, 0);
    chk("t6_rst_grant", 32'(grant_o), 0);
    chk("t6_rst_seq", 32'(pkt_seq_o), 0);
    chk("t6_rst_re", 32'({samp_re_o, cmd_re_o}), 0);
    do_reset();
    load_samp(24'h000500, 32);
    expect_pkt("t6_fresh", 1'b0, 8'd0, 32'h500, 1'b1);

    chk("hold_stable", 32'(hold_err), 0);
    chk("re_rules", 32'(re_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ft_tx_sched.md
Name: ft_tx_sched

Overview:
- Packet scheduler for the FT600 write path.
- Shares the single FT write stream between two sources: the AFE RX sample FIFO (IQ pairs) and the CPU output command FIFO.
- Arbitrates at packet granularity and emits one header word before each packet. Sits between both FIFOs' read ports and the FT write-side consumer.
- Both source FIFOs are non-show-ahead: Q is valid one clk after re asserts.

Parameters:
- FT_DATA_WIDTH, 32, output word width.
- IQ_PAIR_WIDTH, 24, sample FIFO word width; must be ≤ FT_DATA_WIDTH.
- PKT_WORDS, 32, payload words per packet; range 1..255.
- MAX_CMD_BURST, 2, consecutive cmd packets allowed before samples are forced in.
- BLKCNT_WIDTH, 4, width of the cmd block count.

Ports:
- clk  in  1  single clock (FT clock domain); all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- loopback  in  1  1 = sample source never granted.
- samp_data_i  in  IQ_PAIR_WIDTH  sample FIFO Q.
- samp_empty_i  in  1  sample FIFO empty.
- samp_enough_i  in  1  sample FIFO holds ≥ PKT_WORDS words.
- samp_re_o  out  1  sample FIFO read enable.
- cmd_data_i  in  FT_DATA_WIDTH  cmd FIFO Q.
- cmd_empty_i  in  1  cmd FIFO empty.
- cmd_blkcnt_i  in  BLKCNT_WIDTH  complete PKT_WORDS blocks queued in cmd FIFO.
- cmd_re_o  out  1  cmd FIFO read enable.
- tx_data_o  out  FT_DATA_WIDTH  output word.
- tx_valid_o  out  1  tx_data_o valid.
- tx_ready_i  in  1  consumer accepts word when valid&ready.
- grant_o  out  2  00 none, 01 samples, 10 cmd.
- pkt_seq_o  out  8  sequence number of current/last packet.
- underrun_o  out  1  sticky: granted source empty mid-packet.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - All outputs 0; pkt_seq_o=0; cmd streak counter=0; internal buffer empty.
  - Reset mid-packet truncates the packet with no recovery word.
- States: IDLE -> HDR -> BODY -> IDLE.
- IDLE arbitration, evaluated every clk:
  - cmd_ok = cmd_blkcnt_i≠0.
  - samp_ok = samp_enough_i & ~loopback.
  - If cmd_ok & ~(streak==MAX_CMD_BURST & samp_ok): grant cmd, streak++ (saturating).
  - Else if samp_ok: grant samples, streak=0.
  - Else stay IDLE, grant_o=00.
  - On a grant at cycle N, the header is presented at N+1.
- HDR:
  - tx_data_o = {8'hA5, src, 7'b0, seq, PKT_WORDS[7:0]}; src=1 for cmd, 0 for samples.
  - Zero-extend the header when FT_DATA_WIDTH>32.
  - Held until valid&ready. seq is then incremented (wraps 255->0) and the state goes to BODY.
  - FIFO reads may be prefetched during HDR.
- BODY:
  - Transfers exactly PKT_WORDS payload words from the granted source.
  - Sample words are {zeros, samp_data_i}, zero-padded to FT_DATA_WIDTH. Cmd words pass through unchanged.
  - After the last payload word handshakes, return to IDLE. grant_o clears the same cycle.
- Read pacing / skid buffer:
  - 2-entry output skid buffer.
  - re_o asserts only when (buffered words + in-flight read) < 2, payload words remaining to be read > 0, and the source is not empty.
  - Reads never exceed PKT_WORDS per packet.
  - At most one of samp_re_o/cmd_re_o is high. Neither is high in IDLE.
- tx_ready_i low: tx_data_o and tx_valid_o hold stable. No words are lost or duplicated.
- Back-to-back: at least one IDLE cycle between packets. Throughput in BODY is 1 word/clk while ready=1.
- Underrun: in BODY, if the granted source is empty while payload reads remain, re_o stays low, underrun_o is set (sticky until reset), and the block waits for data. The packet is never shortened.
- loopback asserted mid sample packet: the current packet completes; it only affects the next arbitration.
- cmd_blkcnt_i is sampled only in IDLE.

Test Plan:
- Reset; samp_enough=1 and 40 samples 0x000001..0x000028; ready=1 -> header 0xA5000020, then 32 words 0x00000001..0x00000020. grant_o=01 during the packet, seq=1 after.
- cmd_blkcnt=3 and samp_enough=1 constantly -> packet order cmd, cmd, samp, cmd, cmd, samp. Header bit23 follows 1,1,0,1,1,0; seq 0..5.
- tx_ready_i toggled pseudo-randomly during a cmd packet of words 0xC0DE0000+i -> output equals the input sequence exactly. Header appears once. cmd_re_o pulses exactly 32 times.
- samp_empty_i forced to 1 after 10 payload words -> underrun_o=1, output stalls, then resumes with word 11 when data returns. Total payload stays 32.
- loopback=1 with samp_enough=1 and cmd_blkcnt=0 -> grant_o stays 00 and samp_re_o never asserts. With cmd_blkcnt=1, a cmd packet is sent.
- 256 sample packets -> seq wraps 0xFF->0x00. reset_n pulled low mid-BODY -> all outputs 0 immediately and seq=0; the next packet starts with a fresh header.
